// File: rtl/cfg_tile_responder.sv
// Tile-side config bus responder: decodes {reg, feature, tile} addresses, writes a local register bank, answers readbacks.
// Writes land at the accepting edge. Read data is valid one cycle after acceptance and is held until read_ready_in; no new request is taken meanwhile.
module cfg_tile_responder #(
  parameter logic [15:0] TILE_ID    = 16'h0015,
  parameter logic [7:0]  FEATURE_ID = 8'h00,
  parameter int          NUM_REGS   = 4
) (
  input  logic                     clk_in,
  input  logic                     reset_in,
  input  logic [31:0]              config_addr_in,
  input  logic [31:0]              config_data_in,
  input  logic                     config_valid_in,
  input  logic                     config_read_in,
  output logic                     config_ready_out,
  output logic [31:0]              read_data_out,
  output logic                     read_valid_out,
  input  logic                     read_ready_in,
  output logic [32*NUM_REGS-1:0]   cfg_regs_out,
  output logic [15:0]              write_count_out,
  output logic                     addr_err_out
);

  localparam logic [7:0] NUM_REGS_B = 8'(NUM_REGS);

  typedef enum logic {IDLE, RESP} state_t;

  state_t      state, state_nxt;
  logic [7:0]  reg_idx;
  logic        hit;
  logic        idx_ok;
  logic        accept;
  logic        wr_hit;
  logic        rd_hit;
  logic [31:0] rd_sel;

  assign reg_idx = config_addr_in[31:24];
  assign hit     = (config_addr_in[15:0] == TILE_ID) && (config_addr_in[23:16] == FEATURE_ID);
  assign idx_ok  = reg_idx < NUM_REGS_B;
  assign accept  = config_valid_in && config_ready_out;
  assign wr_hit  = accept && hit && !config_read_in;
  assign rd_hit  = accept && hit && config_read_in;

  // Out-of-range reads return zero rather than aliasing onto a real register.
  always_comb begin
    rd_sel = 32'h0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (reg_idx == 8'(i)) rd_sel = cfg_regs_out[32*i +: 32];
    end
  end

  always_comb begin
    state_nxt        = state;
    config_ready_out = 1'b0;
    case (state)
      IDLE: begin
        config_ready_out = 1'b1;
        if (rd_hit) state_nxt = RESP;
      end
      RESP: begin
        if (read_ready_in) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) state <= IDLE;
    else           state <= state_nxt;
  end

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      cfg_regs_out <= '0;
    end else if (wr_hit && idx_ok) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (reg_idx == 8'(i)) cfg_regs_out[32*i +: 32] <= config_data_in;
      end
    end
  end

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      write_count_out <= 16'h0;
      addr_err_out    <= 1'b0;
    end else begin
      if (wr_hit && idx_ok && (write_count_out != 16'hFFFF))
        write_count_out <= write_count_out + 16'h1;
      if ((wr_hit || rd_hit) && !idx_ok)
        addr_err_out <= 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      read_data_out  <= 32'h0;
      read_valid_out <= 1'b0;
    end else if (rd_hit) begin
      read_data_out  <= rd_sel;
      read_valid_out <= 1'b1;
    end else if (state == RESP && read_ready_in) begin
      read_valid_out <= 1'b0;
    end
  end

endmodule
